// File: rtl/pc_unit_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_ras
//  Purpose  : IF-stage program counter with next-PC selection (exception,
//             branch, return, jump/call, sequential) and a circular
//             return-address stack for jal / jr $ra pairs.
//  Option   : define PC_ALIGN_CHECK_EN to force next-PC bits[1:0] to zero
//             and pulse MisalignedFault on each such forced update.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit_ras #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Return,
    input  logic [WIDTH-1:0] ReturnTarget,
    input  logic             Exception,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlus,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasOverflow,
    output logic             MisalignedFault
);

    localparam int               PTR_W = $clog2(RAS_DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;     // next free slot; top of stack is ras_ptr-1
    logic [CNT_W-1:0] ras_count;
    logic [WIDTH-1:0] pc;
    logic             overflow;

    logic [WIDTH-1:0] next_raw;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] push_val;
    logic [PTR_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;
    logic             misaligned;
    logic             update;

    assign PCResult    = pc;
    assign PCPlus      = pc + INC_V;
    assign RasEmpty    = (ras_count == '0);
    assign RasFull     = (ras_count == FULL_COUNT);
    assign RasOverflow = overflow;
    assign top_idx     = ras_ptr - PTR_W'(1);
    assign update      = Exception | PCWrite;

    // Priority select of the next PC; only the winning source may touch the RAS
    always_comb begin
        next_raw = PCPlus;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (Exception) begin
            next_raw = EXC_VECTOR;
        end else if (BranchTaken) begin
            next_raw = BranchTarget;
        end else if (Return) begin
            if (!RasEmpty) begin
                next_raw = ras_mem[top_idx];
                do_pop   = 1'b1;
            end else begin
                next_raw = ReturnTarget;
            end
        end else if (Jump) begin
            next_raw = JumpTarget;
            do_push  = Call;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault;

    assign misaligned      = |next_raw[1:0];
    assign next_pc         = {next_raw[WIDTH-1:2], 2'b00};
    assign push_val        = {PCPlus[WIDTH-1:2], 2'b00};
    assign MisalignedFault = fault;

    // Fault pulses for the single cycle following a forced-alignment update
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fault <= 1'b0;
        end else begin
            fault <= update & misaligned;
        end
    end
`else
    assign misaligned      = 1'b0;
    assign next_pc         = next_raw;
    assign push_val        = PCPlus;
    assign MisalignedFault = misaligned;
`endif

    // PC, stack pointer, occupancy and sticky overflow flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc        <= RESET_VECTOR;
            ras_ptr   <= '0;
            ras_count <= '0;
            overflow  <= 1'b0;
        end else if (Exception) begin
            pc        <= next_pc;
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (PCWrite) begin
            pc <= next_pc;
            if (do_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (RasFull) begin
                    overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                ras_ptr   <= top_idx;
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

    // Stack storage; entries are not cleared by reset, a push into a full
    // stack overwrites the oldest entry because the pointer wraps
    always_ff @(posedge Clk) begin
        if (Reset && PCWrite && !Exception && do_push) begin
            ras_mem[ras_ptr] <= push_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit_ras.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit_ras
//  Purpose  : Directed self-checking bench for pc_unit_ras (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit_ras;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Call;
    logic        Return;
    logic [31:0] ReturnTarget;
    logic        Exception;
    logic [31:0] PCResult;
    logic [31:0] PCPlus;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasOverflow;
    logic        MisalignedFault;

    int checks   = 0;
    int failures = 0;

    pc_unit_ras dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCWrite        (PCWrite),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .Jump           (Jump),
        .JumpTarget     (JumpTarget),
        .Call           (Call),
        .Return         (Return),
        .ReturnTarget   (ReturnTarget),
        .Exception      (Exception),
        .PCResult       (PCResult),
        .PCPlus         (PCPlus),
        .RasEmpty       (RasEmpty),
        .RasFull        (RasFull),
        .RasOverflow    (RasOverflow),
        .MisalignedFault(MisalignedFault)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already applied are sampled at the edge, outputs read 1ns later
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        PCWrite = 1'b1; BranchTaken = 1'b0; Jump = 1'b0; Call = 1'b0;
        Return = 1'b0; Exception = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0; ReturnTarget = 32'h0;
        idle();
        #3;
        check("rst_pc",       PCResult, 32'h0);
        check("rst_pcplus",   PCPlus, 32'h4);
        check("rst_empty",    {31'b0, RasEmpty}, 32'h1);
        check("rst_full",     {31'b0, RasFull}, 32'h0);
        check("rst_overflow", {31'b0, RasOverflow}, 32'h0);
        check("rst_fault",    {31'b0, MisalignedFault}, 32'h0);
        #4 Reset = 1'b1;

        // Run sequentially to 0x40, then async reset mid-cycle
        for (int i = 0; i < 16; i++) step();
        check("seq_0x40", PCResult, 32'h40);
        #2 Reset = 1'b0;
        #1;
        check("async_rst_pc",    PCResult, 32'h0);
        check("async_rst_empty", {31'b0, RasEmpty}, 32'h1);
        Reset = 1'b1;
        step(); check("post_rst_1", PCResult, 32'h4);
        step(); check("post_rst_2", PCResult, 32'h8);
        step(); check("post_rst_3", PCResult, 32'hC);
        step(); check("seq_0x10",   PCResult, 32'h10);

        // Stall drops a branch request
        PCWrite = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h100;
        step(); check("stall_1", PCResult, 32'h10);
        step(); check("stall_2", PCResult, 32'h10);
        idle();
        step(); check("stall_release", PCResult, 32'h14);
        check("pcplus_0x14", PCPlus, 32'h18);
        step(); step(); step();
        check("seq_0x20", PCResult, 32'h20);

        // Call / return pair, then return on empty stack
        Jump = 1'b1; Call = 1'b1; JumpTarget = 32'h200;
        step(); check("call_pc", PCResult, 32'h200);
        check("call_nonempty", {31'b0, RasEmpty}, 32'h0);
        idle(); Return = 1'b1; ReturnTarget = 32'h300;
        step(); check("ret_pc", PCResult, 32'h24);
        check("ret_empty", {31'b0, RasEmpty}, 32'h1);
        step(); check("ret_fallback", PCResult, 32'h300);

        // Five nested calls overflow a 4-deep stack
        idle(); BranchTaken = 1'b1; BranchTarget = 32'h0;
        step(); check("br_to_0", PCResult, 32'h0);
        idle(); Jump = 1'b1; Call = 1'b1;
        JumpTarget = 32'h100; step();
        JumpTarget = 32'h200; step();
        JumpTarget = 32'h300; step();
        JumpTarget = 32'h400; step();
        check("four_calls_full", {31'b0, RasFull}, 32'h1);
        check("four_calls_noovf", {31'b0, RasOverflow}, 32'h0);
        JumpTarget = 32'h500; step();
        check("five_calls_pc",   PCResult, 32'h500);
        check("five_calls_full", {31'b0, RasFull}, 32'h1);
        check("five_calls_ovf",  {31'b0, RasOverflow}, 32'h1);
        idle(); Return = 1'b1; ReturnTarget = 32'h900;
        step(); check("pop_1", PCResult, 32'h404);
        check("pop_1_notfull", {31'b0, RasFull}, 32'h0);
        step(); check("pop_2", PCResult, 32'h304);
        step(); check("pop_3", PCResult, 32'h204);
        step(); check("pop_4", PCResult, 32'h104);
        check("pop_4_empty", {31'b0, RasEmpty}, 32'h1);
        step(); check("pop_fallback", PCResult, 32'h900);
        check("ovf_sticky", {31'b0, RasOverflow}, 32'h1);

        // Exception beats branch/return and ignores stall, clears the stack
        idle(); Jump = 1'b1; Call = 1'b1; JumpTarget = 32'h600;
        step(); check("pre_exc_nonempty", {31'b0, RasEmpty}, 32'h0);
        idle(); PCWrite = 1'b0; Exception = 1'b1; BranchTaken = 1'b1;
        BranchTarget = 32'h700; Return = 1'b1;
        step(); check("exc_pc", PCResult, 32'h180);
        check("exc_empty", {31'b0, RasEmpty}, 32'h1);
        check("exc_ovf_kept", {31'b0, RasOverflow}, 32'h1);

        // Call under a branch and Call without Jump do not push
        idle(); BranchTaken = 1'b1; BranchTarget = 32'h700; Jump = 1'b1; Call = 1'b1;
        step(); check("br_over_call", PCResult, 32'h700);
        check("br_over_call_empty", {31'b0, RasEmpty}, 32'h1);
        idle(); Call = 1'b1;
        step(); check("call_no_jump", PCResult, 32'h704);
        check("call_no_jump_empty", {31'b0, RasEmpty}, 32'h1);

        // Modulo wrap of the sequential path
        idle(); BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        step(); check("pre_wrap", PCResult, 32'hFFFF_FFFC);
        check("pcplus_wrap", PCPlus, 32'h0);
        idle();
        step(); check("wrap", PCResult, 32'h0);

        // Misaligned branch target
        BranchTaken = 1'b1; BranchTarget = 32'h102;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pc",    PCResult, 32'h100);
        check("misalign_fault", {31'b0, MisalignedFault}, 32'h1);
        idle();
        step(); check("after_misalign_pc", PCResult, 32'h104);
`else
        check("misalign_pc",    PCResult, 32'h102);
        check("misalign_fault", {31'b0, MisalignedFault}, 32'h0);
        idle();
        step(); check("after_misalign_pc", PCResult, 32'h106);
`endif
        check("fault_cleared", {31'b0, MisalignedFault}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the MIPS datapath.
- Holds the fetch PC and selects the next PC from sequential, branch, jump, call, return and exception sources.
- Contains a small return-address stack (RAS) so jal/jr $ra pairs redirect without a register-file read.
- Sits in the IF stage; feeds instruction memory and the IF/ID pipeline register.

Parameters:
WIDTH, 32, PC and address width in bits
RESET_VECTOR, 32'h00000000, PCResult value after reset
EXC_VECTOR, 32'h00000180, PC loaded on Exception
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, RAS entries (power of 2, >=2)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
PCWrite  in  1  1 = PC may update; 0 = stall
BranchTaken  in  1  resolved taken branch
BranchTarget  in  WIDTH  branch destination
Jump  in  1  j/jal
JumpTarget  in  WIDTH  jump destination
Call  in  1  jal: push return address (qualified by Jump)
Return  in  1  jr $ra: pop RAS
ReturnTarget  in  WIDTH  register value used when RAS is empty
Exception  in  1  redirect to EXC_VECTOR
PCResult  out  WIDTH  current fetch PC
PCPlus  out  WIDTH  PCResult+INC (combinational)
RasEmpty  out  1  RAS count == 0
RasFull  out  1  RAS count == RAS_DEPTH
RasOverflow  out  1  sticky: a push overwrote a valid entry
MisalignedFault  out  1  see Optional Feature

Behaviour:
- Reset low (any time, asynchronous): PCResult=RESET_VECTOR, RAS count=0, top pointer=0, RasOverflow=0, MisalignedFault=0. Entries are not cleared.
- Updates occur on the rising edge of Clk; PCResult changes 1 cycle after inputs are sampled.
- Next-PC priority, highest first:
  1. Exception -> EXC_VECTOR.
  2. BranchTaken -> BranchTarget.
  3. Return -> RAS top when non-empty (pop), else ReturnTarget (no pop).
  4. Jump -> JumpTarget; if Call is also high, push PCResult+INC.
  5. Otherwise -> PCResult+INC.
- Exception ignores PCWrite and also clears the RAS (count=0, pointer=0); RasOverflow is kept.
- PCWrite=0 without Exception: PCResult, RAS and all flags hold. Requests are dropped, not queued.
- Only the winning source acts. A lower-priority Call or Return under Branch/Exception does not touch the RAS.
- Call without Jump is ignored. Call and Return together: Return wins, no push.
- Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH; RasOverflow set (sticky until reset).
- Pop when empty is not possible (falls back to ReturnTarget).
- Arithmetic is modulo 2^WIDTH: PCResult=all-ones-minus-3 plus INC wraps to 0.
- Internal state: RAS array RAS_DEPTH x WIDTH, pointer of log2(RAS_DEPTH) bits, count of log2(RAS_DEPTH)+1 bits.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: when an update occurs and the selected next PC has bits[1:0]!=0, the low two bits are forced to 0 in PCResult. MisalignedFault pulses high for exactly that one cycle, registered alongside the PCResult update. A RAS pop or push of a misaligned value stores or uses the forced value.
- Not defined: the next PC is loaded unmodified and MisalignedFault is tied 0.

Test Plan:
- Reset low mid-run (PCResult=0x40) -> PCResult=0x0 immediately with no clock edge, RasEmpty=1; after release, 3 edges -> 0x4, 0x8, 0xC.
- PCResult=0x10, PCWrite=0 for 2 cycles with BranchTaken=1, BranchTarget=0x100 -> PC stays 0x10; PCWrite=1 with branch dropped -> 0x14.
- At PC=0x20, Jump+Call to 0x200 -> PC=0x200, RAS top=0x24; later Return -> PC=0x24, RasEmpty=1; Return again with ReturnTarget=0x300 -> PC=0x300.
- 5 successive Jump+Call at PCs 0x0,0x100,0x200,0x300,0x400 (RAS_DEPTH=4) -> RasFull=1, RasOverflow=1; pops return 0x404, 0x304, 0x204, 0x104, then RasEmpty and ReturnTarget is used.
- Same cycle Exception+BranchTaken+Return with PCWrite=0 and non-empty RAS -> PC=0x180, RasEmpty=1 next cycle.
- With PC_ALIGN_CHECK_EN, BranchTarget=0x102 -> PC=0x100, MisalignedFault=1 for 1 cycle; without the macro -> PC=0x102, fault=0.
